// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage core.
// Tracks in-flight destinations (entry0 = EX, entry1 = MEM, entry2 = WB, ...).
// It produces the EX/ID forwarding selects and the ID stall / EX bubble request.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_forward_ctrl #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]           id_rs,
    input  logic [NUM_SRC-1:0]                  id_src_used,
    input  logic [ADDR_W-1:0]                   id_rd,
    input  logic                                id_regwrite,
    input  logic                                id_is_load,
    input  logic                                id_branch,
    input  logic                                flush_ex,
    output logic                                stall,
    output logic [NUM_SRC*$clog2(DEPTH)-1:0]    ex_fwd_sel,
    output logic [NUM_SRC*$clog2(DEPTH)-1:0]    id_fwd_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_stall_cnt,
    output logic [31:0]                         perf_fwd_cnt
`endif
);

    localparam int unsigned SEL_W = $clog2(DEPTH);
    localparam int unsigned SRC_W = NUM_SRC * ADDR_W;

    // Every entry needs valid/rd/regwrite for matching. Only EX and MEM need
    // is_load, and only the EX entry needs its source operands.
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             regwrite_q, regwrite_d;
    logic [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;
    logic [1:0]                   is_load_q, is_load_d;
    logic [SRC_W-1:0]             src0_q, src0_d;
    logic [NUM_SRC-1:0]           src_used0_q, src_used0_d;

    logic [ADDR_W-1:0]            st_a;
    logic [ADDR_W-1:0]            id_a;
    logic [SEL_W-1:0]             id_sel;
    logic [ADDR_W-1:0]            ex_a;
    logic [SEL_W-1:0]             ex_sel;

    // A producer matches when it will write a non-x0 register equal to the address.
    function automatic logic prod_match(input logic v, input logic w,
                                        input logic [ADDR_W-1:0] prd,
                                        input logic [ADDR_W-1:0] a);
        return v && w && (prd == a) && (a != '0);
    endfunction

    // Stall request: load-use, or a branch whose operand is not ready for the ID compare.
    always_comb begin
        stall = 1'b0;
        st_a  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            st_a = id_rs[i*ADDR_W +: ADDR_W];
            if (id_valid && id_src_used[i]) begin
                if (prod_match(valid_q[0], regwrite_q[0], rd_q[0], st_a) &&
                    (is_load_q[0] || id_branch)) begin
                    stall = 1'b1;
                end
                if (id_branch && is_load_q[1] &&
                    prod_match(valid_q[1], regwrite_q[1], rd_q[1], st_a)) begin
                    stall = 1'b1;
                end
            end
        end
    end

    // ID branch operand selects; scan oldest to youngest so the youngest match wins.
    always_comb begin
        id_fwd_sel = '0;
        id_a       = '0;
        id_sel     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_a   = id_rs[i*ADDR_W +: ADDR_W];
            id_sel = '0;
            if (id_valid && id_src_used[i]) begin
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    // A load sitting in MEM has no data yet to forward.
                    if (prod_match(valid_q[k], regwrite_q[k], rd_q[k], id_a) &&
                        !(k == 1 && is_load_q[1])) begin
                        id_sel = SEL_W'(k);
                    end
                end
            end
            id_fwd_sel[i*SEL_W +: SEL_W] = id_sel;
        end
    end

    // EX operand selects, derived purely from tracker flops.
    always_comb begin
        ex_fwd_sel = '0;
        ex_a       = '0;
        ex_sel     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ex_a   = src0_q[i*ADDR_W +: ADDR_W];
            ex_sel = '0;
            if (valid_q[0] && src_used0_q[i]) begin
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    if (prod_match(valid_q[k], regwrite_q[k], rd_q[k], ex_a)) begin
                        ex_sel = SEL_W'(k);
                    end
                end
            end
            ex_fwd_sel[i*SEL_W +: SEL_W] = ex_sel;
        end
    end

    // Tracker next state: shift toward WB; EX takes the ID instruction or a bubble.
    always_comb begin
        valid_d     = '0;
        regwrite_d  = '0;
        rd_d        = '0;
        is_load_d   = '0;
        src0_d      = '0;
        src_used0_d = '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k]    = valid_q[k-1];
            regwrite_d[k] = regwrite_q[k-1];
            rd_d[k]       = rd_q[k-1];
        end
        is_load_d[1] = is_load_q[0];
        // flush_ex overrides everything; a stall also leaves a bubble in EX.
        if (id_valid && !stall && !flush_ex) begin
            valid_d[0]    = 1'b1;
            regwrite_d[0] = id_regwrite;
            rd_d[0]       = id_rd;
            is_load_d[0]  = id_is_load;
            src0_d        = id_rs;
            src_used0_d   = id_src_used;
        end
    end

    // Tracker registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            regwrite_q  <= '0;
            rd_q        <= '0;
            is_load_q   <= '0;
            src0_q      <= '0;
            src_used0_q <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            rd_q        <= rd_d;
            is_load_q   <= is_load_d;
            src0_q      <= src0_d;
            src_used0_q <= src_used0_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    // Saturating stall-cycle and EX-forward-cycle counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (valid_q[0] && (ex_fwd_sel != '0) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipelined hazard and forwarding controller for the 5-stage RISC-V core.
- Tracks in-flight destination registers in an internal shift tracker, one entry per stage EX..WB (and later, if DEPTH > 3).
- Generates registered-state forwarding selects for EX-stage ALU operands and ID-stage branch comparators, plus the ID stall / EX bubble request.
- Generalises branch/ALU forwarding to NUM_SRC operands and DEPTH stages, and adds load-use and branch-in-ID stall generation.

Parameters:
- NUM_SRC, 2, source operands per instruction (rs1, rs2, ...).
- DEPTH, 3, tracker entries: entry0 = EX, entry1 = MEM, entry2 = WB, and further entries for extra write-back stages. Minimum 3.
- ADDR_W, 5, register address width.
- SEL_W (localparam), $clog2(DEPTH), select width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NUM_SRC*ADDR_W  ID source addresses; operand i in bits [i*ADDR_W +: ADDR_W]
- id_src_used  in  NUM_SRC  operand i is actually read
- id_rd  in  ADDR_W  ID destination
- id_regwrite  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_branch  in  1  ID instruction is a branch resolved in ID
- flush_ex  in  1  kill the instruction entering EX this cycle
- stall  out  1  hold IF/ID, insert bubble into EX
- ex_fwd_sel  out  NUM_SRC*SEL_W  EX operand selects
- id_fwd_sel  out  NUM_SRC*SEL_W  ID branch operand selects

Behaviour:
- Tracker entry fields: valid, rd, regwrite, is_load, src[NUM_SRC], src_used[NUM_SRC].
- Reset (synchronous): all entries valid=0. Consequently stall=0 and all selects 0 in the cycle after reset is sampled. Reset mid-stall aborts the stall; there is no residual state.
- Every clock edge:
  - Entries k = 1..DEPTH-1 load entry k-1.
  - Entry0 loads the ID instruction fields only if id_valid && !stall && !flush_ex; otherwise entry0 becomes a bubble (valid=0).
  - flush_ex has priority over stall.
- "Producer k matches address a" means: entry k valid && regwrite && rd==a && a!=0. Register x0 never forwards and never stalls.
- Select encoding:
  - 0 = register file.
  - k = forward from entry k (k >= 1).
  - The youngest matching k wins, i.e. the smallest k.
- ex_fwd_sel[i]:
  - Computed only from registered state: entry0.src[i] against entries 1..DEPTH-1.
  - 0 if entry0 is invalid or !src_used[i].
  - Zero-cycle combinational path from tracker flops only.
- id_fwd_sel[i]:
  - id_rs[i] against entries 1..DEPTH-1, excluding entry1 when entry1.is_load (load data is not yet available).
  - 0 when !id_valid or !id_src_used[i].
- stall is combinational. It is 1 iff id_valid and, for some i with id_src_used[i]:
  - (a) entry0 matches and entry0.is_load (load-use), or
  - (b) id_branch and entry0 matches (ALU or load result not ready for ID compare), or
  - (c) id_branch and entry1 matches and entry1.is_load.
- Resulting stall lengths:
  - Load then dependent ALU op: 1 cycle.
  - ALU op then dependent branch: 1 cycle.
  - Load then dependent branch: 2 cycles.
- Dependence only through an unused operand: no stall.
- Producer beyond entry DEPTH-1: the register file is assumed written, so select 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cnt (32 bits) and perf_fwd_cnt (32 bits).
  - perf_stall_cnt increments each cycle stall=1.
  - perf_fwd_cnt increments each cycle entry0 is valid and any ex_fwd_sel is nonzero.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles with garbage on the ID inputs -> stall=0, ex_fwd_sel=0, id_fwd_sel=0 on the first cycle after reset deasserts.
- "addi x5,x0,1" then "add x6,x5,x5" back-to-back -> with add in EX, ex_fwd_sel = {1,1}, no stall. With one nop between them -> {2,2}.
- "lw x7,0(x1)" then "add x8,x7,x2" -> stall=1 for exactly 1 cycle, bubble in EX, then ex_fwd_sel[0]=2 and ex_fwd_sel[1]=0.
- "addi x3,..." then "beq x3,x4" -> 1 stall cycle, then id_fwd_sel[0]=1. "lw x3" then "beq x3,x4" -> 2 stall cycles, then id_fwd_sel[0]=2.
- "addi x0,x0,5" then "add x1,x0,x0" -> no stall, all selects 0. "lw x9" then "addi x2,x1,4", with id_rs[1]=9 but id_src_used[1]=0 -> no stall.
- Load-use stall with flush_ex=1 in the same cycle -> entry0 is a bubble. Next cycle reset=1 mid-sequence -> all outputs 0 the cycle after.
